dla_axi4_m: RTL and testbench

DLA_AXI4_M -- requirements
Module: dla_axi4_m

---
 rtl/dla_axi4_m_if.sv | 87 ++++++++
 rtl/dla_axi4_m.sv | 155 +++++++++++++++
 tb/tb_dla_axi4_m.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dla_axi4_m_if.sv
// AXI4 bus bundle shared by the DLA manager and its subordinate.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/dla_axi4_m.sv
// Single-beat AXI4 manager with independent write and read engines started by level requests.
// state       | meaning
// W_IDLE      | wait for req_i[0], latch write address and data
// W_ADDR_DATA | AW and W valid, each drops after its own handshake
// W_RESP      | bready high, wait for B
// W_DONE      | rsp_o[0] pulse
// R_IDLE      | wait for req_i[1], latch read address
// R_ADDR      | AR valid until accepted
// R_DATA      | rready high, wait for R
// R_DONE      | rsp_o[1] pulse
module dla_axi4_m #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [1:0]                req_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0] pp_data_i,
  output logic [1:0]                rsp_o,
  output logic [AXI_DATA_WIDTH-1:0] dla_data_o,
  AXI_BUS.master                    pp_if
);
  localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

  typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP, W_DONE} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_e;

  w_state_e w_state, w_next;
  r_state_e r_state, r_next;
  logic aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, b_ready_q, b_ready_d;
  logic ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [AXI_DATA_WIDTH-1:0] wr_data_q, wr_data_d, rd_data_q, rd_data_d;
  logic [1:0] rsp_q, rsp_d;
  logic aw_pend, w_pend;

  // A channel is still pending only while its valid is up and not yet accepted.
  assign aw_pend = aw_valid_q & ~pp_if.aw_ready;
  assign w_pend  = w_valid_q & ~pp_if.w_ready;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      rsp_q      <= 2'b00;
    end else begin
      w_state    <= w_next;
      r_state    <= r_next;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      rsp_q      <= rsp_d;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:      if (req_i[0]) w_next = W_ADDR_DATA;
      W_ADDR_DATA: if (!aw_pend && !w_pend) w_next = W_RESP;
      W_RESP:      if (pp_if.b_valid && b_ready_q) w_next = W_DONE;
      default:     w_next = W_IDLE;
    endcase
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (req_i[1]) r_next = R_ADDR;
      R_ADDR:  if (ar_valid_q && pp_if.ar_ready) r_next = R_DATA;
      R_DATA:  if (pp_if.r_valid && r_ready_q) r_next = R_DONE;
      default: r_next = R_IDLE;
    endcase
  end

  // Next values of the registered bus controls, derived from the state transition.
  always_comb begin
    aw_valid_d = aw_pend;
    w_valid_d  = w_pend;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (w_state == W_IDLE && req_i[0]) begin
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      wr_addr_d  = axi_wr_addr_i;
      wr_data_d  = pp_data_i;
    end
    b_ready_d  = (w_next == W_RESP);
    ar_valid_d = ar_valid_q & ~pp_if.ar_ready;
    rd_addr_d  = rd_addr_q;
    if (r_state == R_IDLE && req_i[1]) begin
      ar_valid_d = 1'b1;
      rd_addr_d  = axi_rd_addr_i;
    end
    r_ready_d = (r_next == R_DATA);
    rd_data_d = rd_data_q;
    if (r_state == R_DATA && pp_if.r_valid && r_ready_q) rd_data_d = pp_if.r_data;
    rsp_d = {r_next == R_DONE, w_next == W_DONE};
  end

  assign rsp_o      = rsp_q;
  assign dla_data_o = rd_data_q;

  assign pp_if.aw_id     = '0;
  assign pp_if.aw_addr   = wr_addr_q;
  assign pp_if.aw_len    = 8'd0;
  assign pp_if.aw_size   = AXI_SIZE;
  assign pp_if.aw_burst  = 2'b01;
  assign pp_if.aw_lock   = 1'b0;
  assign pp_if.aw_cache  = 4'd0;
  assign pp_if.aw_prot   = 3'd0;
  assign pp_if.aw_qos    = 4'd0;
  assign pp_if.aw_region = 4'd0;
  assign pp_if.aw_atop   = 6'd0;
  assign pp_if.aw_user   = '0;
  assign pp_if.aw_valid  = aw_valid_q;
  assign pp_if.w_data    = wr_data_q;
  assign pp_if.w_strb    = '1;
  assign pp_if.w_last    = 1'b1;
  assign pp_if.w_user    = '0;
  assign pp_if.w_valid   = w_valid_q;
  assign pp_if.b_ready   = b_ready_q;
  assign pp_if.ar_id     = '0;
  assign pp_if.ar_addr   = rd_addr_q;
  assign pp_if.ar_len    = 8'd0;
  assign pp_if.ar_size   = AXI_SIZE;
  assign pp_if.ar_burst  = 2'b01;
  assign pp_if.ar_lock   = 1'b0;
  assign pp_if.ar_cache  = 4'd0;
  assign pp_if.ar_prot   = 3'd0;
  assign pp_if.ar_qos    = 4'd0;
  assign pp_if.ar_region = 4'd0;
  assign pp_if.ar_user   = '0;
  assign pp_if.ar_valid  = ar_valid_q;
  assign pp_if.r_ready   = r_ready_q;

  // Responses are accepted regardless of status or sideband content.
  logic unused_rsp_fields;
  assign unused_rsp_fields = ^{pp_if.b_id, pp_if.b_resp, pp_if.b_user,
                               pp_if.r_id, pp_if.r_resp, pp_if.r_last, pp_if.r_user};
endmodule

// File: tb/tb_dla_axi4_m.sv
// Bench for dla_axi4_m: randomized subordinate plus a transaction-level expectation model.
module tb_dla_axi4_m;
  localparam int AW = 32;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    rsp;
  logic [DW-1:0] dla_data;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) bus ();

  dla_axi4_m #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req),
    .axi_wr_addr_i(wr_addr), .axi_rd_addr_i(rd_addr), .pp_data_i(wdata),
    .rsp_o(rsp), .dla_data_o(dla_data), .pp_if(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // expectation model: every request yields exactly one AW+W+B (or AR+R) carrying the
  // values present when it was issued, then a single one-cycle completion pulse
  logic [AW-1:0] exp_wr_addr = '0;
  logic [AW-1:0] exp_rd_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_dla = '0;
  logic          rd_fixed = 1'b0;
  logic [DW-1:0] rd_fixed_val = '0;
  int            ready_mode = 0;   // 0 random, 1 W before AW, 2 always ready, 3 never ready
  bit            held_mode = 1'b0;
  int            held_start_cyc = 0;

  int cyc = 0;
  int wr_pulses = 0, rd_pulses = 0, aw_total = 0, ar_total = 0;
  int aw_since = 0, w_since = 0, b_since = 0, ar_since = 0, r_since = 0;
  int last_wr_pulse_cyc = -1, last_rd_pulse_cyc = -1;
  bit got_aw = 0, got_w = 0, got_ar = 0;
  int b_dly = 0, r_dly = 0;
  bit b_hs_prev = 0, r_hs_prev = 0;
  bit prev_aw_pend = 0, prev_w_pend = 0, prev_ar_pend = 0;
  bit prev_aw_valid = 0, prev_ar_valid = 0;
  logic [AW-1:0] prev_aw_addr = '0, prev_ar_addr = '0;
  logic [DW-1:0] prev_w_data = '0;
  logic [1:0] prev_rsp = 2'b00;

  // subordinate + monitor: drives the inputs for the coming edge, then predicts its handshakes
  always @(negedge clk) begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    cyc++;
    if (!rstn) begin
      bus.aw_ready = 0; bus.w_ready = 0; bus.ar_ready = 0;
      bus.b_valid = 0; bus.r_valid = 0;
      bus.b_id = '0; bus.b_user = '0; bus.b_resp = 2'b00;
      bus.r_id = '0; bus.r_user = '0; bus.r_resp = 2'b00; bus.r_last = 1'b1; bus.r_data = '0;
      got_aw = 0; got_w = 0; got_ar = 0; b_hs_prev = 0; r_hs_prev = 0;
      aw_since = 0; w_since = 0; b_since = 0; ar_since = 0; r_since = 0;
      prev_aw_pend = 0; prev_w_pend = 0; prev_ar_pend = 0;
      prev_aw_valid = 0; prev_ar_valid = 0; prev_rsp = 2'b00;
      exp_dla = '0;
    end else begin
      if (b_hs_prev) bus.b_valid = 0;
      if (r_hs_prev) bus.r_valid = 0;
      case (ready_mode)
        0: begin
          bus.aw_ready = ($urandom_range(0, 2) == 0);
          bus.w_ready  = ($urandom_range(0, 2) == 0);
          bus.ar_ready = ($urandom_range(0, 2) == 0);
        end
        1: begin bus.w_ready = 1; bus.aw_ready = got_w; bus.ar_ready = 1; end
        2: begin bus.w_ready = 1; bus.aw_ready = 1; bus.ar_ready = 1; end
        default: begin bus.w_ready = 0; bus.aw_ready = 0; bus.ar_ready = 0; end
      endcase
      if (!bus.b_valid && got_aw && got_w) begin
        if (b_dly == 0) begin bus.b_valid = 1; bus.b_resp = 2'($urandom_range(0, 3)); end
        else b_dly--;
      end
      if (!bus.r_valid && got_ar) begin
        if (r_dly == 0) begin
          bus.r_valid = 1;
          bus.r_resp = 2'($urandom_range(0, 3));
          bus.r_data = rd_fixed ? rd_fixed_val : {$urandom, $urandom};
        end else r_dly--;
      end

      aw_hs = bus.aw_valid & bus.aw_ready;
      w_hs  = bus.w_valid & bus.w_ready;
      b_hs  = bus.b_valid & bus.b_ready;
      ar_hs = bus.ar_valid & bus.ar_ready;
      r_hs  = bus.r_valid & bus.r_ready;

      if (prev_aw_pend) check("aw_stable", {bus.aw_valid, bus.aw_addr}, {1'b1, prev_aw_addr});
      if (prev_w_pend)  check("w_stable", {63'd0, bus.w_valid}, 64'd1);
      if (prev_w_pend)  check("w_data_stable", bus.w_data, prev_w_data);
      if (prev_ar_pend) check("ar_stable", {bus.ar_valid, bus.ar_addr}, {1'b1, prev_ar_addr});

      if (aw_hs) begin
        check("aw_addr", bus.aw_addr, exp_wr_addr);
        check("aw_attr", {bus.aw_len, bus.aw_size, bus.aw_burst, bus.aw_id, bus.aw_lock, bus.aw_cache,
                          bus.aw_prot, bus.aw_qos, bus.aw_region, bus.aw_atop, bus.aw_user},
              {8'd0, 3'd3, 2'b01, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 1'b0});
        got_aw = 1; aw_since++; aw_total++;
        b_dly = $urandom_range(0, 4);
      end
      if (w_hs) begin
        check("w_data", bus.w_data, exp_wdata);
        check("w_strb_last", {bus.w_strb, bus.w_last, bus.w_user}, {8'hFF, 1'b1, 1'b0});
        got_w = 1; w_since++;
      end
      if (b_hs) begin got_aw = 0; got_w = 0; b_since++; end
      if (ar_hs) begin
        check("ar_addr", bus.ar_addr, exp_rd_addr);
        check("ar_attr", {bus.ar_len, bus.ar_size, bus.ar_burst, bus.ar_id, bus.ar_lock, bus.ar_cache,
                          bus.ar_prot, bus.ar_qos, bus.ar_region, bus.ar_user},
              {8'd0, 3'd3, 2'b01, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 1'b0});
        got_ar = 1; ar_since++; ar_total++;
        r_dly = $urandom_range(0, 4);
      end

      check("dla_hold", dla_data, exp_dla);

      if (rsp[0]) begin
        check("wr_pulse_len", {63'd0, prev_rsp[0]}, 64'd0);
        check("wr_txn_beats", {aw_since[7:0], w_since[7:0], b_since[7:0]}, {8'd1, 8'd1, 8'd1});
        aw_since = 0; w_since = 0; b_since = 0;
        wr_pulses++; last_wr_pulse_cyc = cyc;
      end
      if (rsp[1]) begin
        check("rd_pulse_len", {63'd0, prev_rsp[1]}, 64'd0);
        check("rd_txn_beats", {ar_since[7:0], r_since[7:0]}, {8'd1, 8'd1});
        ar_since = 0; r_since = 0;
        rd_pulses++; last_rd_pulse_cyc = cyc;
      end

      if (held_mode && bus.aw_valid && !prev_aw_valid && last_wr_pulse_cyc >= held_start_cyc)
        check("wr_restart_gap", 64'(cyc - last_wr_pulse_cyc), 64'd2);
      if (held_mode && bus.ar_valid && !prev_ar_valid && last_rd_pulse_cyc >= held_start_cyc)
        check("rd_restart_gap", 64'(cyc - last_rd_pulse_cyc), 64'd2);

      if (r_hs) begin exp_dla = bus.r_data; got_ar = 0; r_since++; end

      b_hs_prev = b_hs; r_hs_prev = r_hs;
      prev_aw_pend = bus.aw_valid & ~bus.aw_ready; prev_aw_addr = bus.aw_addr;
      prev_w_pend  = bus.w_valid & ~bus.w_ready;   prev_w_data  = bus.w_data;
      prev_ar_pend = bus.ar_valid & ~bus.ar_ready; prev_ar_addr = bus.ar_addr;
      prev_aw_valid = bus.aw_valid; prev_ar_valid = bus.ar_valid;
      prev_rsp = rsp;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // issue one request pulse, scramble the inputs, and wait for exactly one completion
  task automatic run_single(input logic [1:0] which, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [AW-1:0] ra);
    int wr_base = wr_pulses;
    int rd_base = rd_pulses;
    int wexp = which[0] ? 1 : 0;
    int rexp = which[1] ? 1 : 0;
    step(1);
    wr_addr = wa; wdata = wd; rd_addr = ra;
    exp_wr_addr = wa; exp_wdata = wd; exp_rd_addr = ra;
    req = which;
    step(1);
    req = 2'b00;
    wr_addr = $urandom; wdata = {$urandom, $urandom}; rd_addr = $urandom;
    for (int i = 0; i < 300 && (wr_pulses - wr_base < wexp || rd_pulses - rd_base < rexp); i++) step(1);
    step(6);
    check("single_wr_count", 64'(wr_pulses - wr_base), 64'(wexp));
    check("single_rd_count", 64'(rd_pulses - rd_base), 64'(rexp));
  endtask

  initial begin
    int wb, rb;
    rstn = 0; req = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 5'b0);
    check("rst_rsp", rsp, 2'b00);
    check("rst_dla", dla_data, '0);
    step(0);
    @(negedge clk); #1 rstn = 1;
    step(10);
    check("idle_no_bus", 64'(aw_total + ar_total + wr_pulses + rd_pulses), 64'd0);
    check("idle_ctrl", {bus.aw_valid, bus.w_valid, bus.ar_valid, rsp}, 5'b0);

    ready_mode = 0;
    run_single(2'b01, 32'h5000, 64'hDEADBEEF0B501E7E, 32'h0);
    rd_fixed = 1; rd_fixed_val = 64'h0123456789ABCDEF;
    run_single(2'b10, 32'h0, 64'h0, 32'h6000);
    check("rd_fixed_dla", dla_data, 64'h0123456789ABCDEF);
    rd_fixed = 0;

    for (int k = 0; k < 5; k++)
      run_single(2'($urandom_range(1, 3)), $urandom, {$urandom, $urandom}, $urandom);

    ready_mode = 1;
    run_single(2'b11, 32'h5000, {$urandom, $urandom}, 32'h6000);
    ready_mode = 2;
    run_single(2'b11, 32'h5008, {$urandom, $urandom}, 32'h6008);

    ready_mode = 0;
    step(1);
    wr_addr = 32'h5000; rd_addr = 32'h6000; wdata = 64'hDEADBEEF0B501E7E;
    exp_wr_addr = 32'h5000; exp_rd_addr = 32'h6000; exp_wdata = 64'hDEADBEEF0B501E7E;
    wb = wr_pulses; rb = rd_pulses;
    held_start_cyc = cyc; held_mode = 1;
    req = 2'b11;
    for (int i = 0; i < 3000 && (wr_pulses - wb < 8 || rd_pulses - rb < 8); i++) step(1);
    held_mode = 0;
    req = 2'b00;
    check("held_wr_progress", 64'(wr_pulses - wb >= 8), 64'd1);
    check("held_rd_progress", 64'(rd_pulses - rb >= 8), 64'd1);
    step(60);
    check("drain_idle", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 5'b0);

    ready_mode = 3;
    step(1);
    req = 2'b11;
    for (int i = 0; i < 20 && !(bus.aw_valid && bus.ar_valid); i++) step(1);
    check("rst_pre_valids", {bus.aw_valid, bus.ar_valid}, 2'b11);
    wb = wr_pulses; rb = rd_pulses;
    @(negedge clk); #2 rstn = 0;
    #1;
    check("async_rst_ctrl", {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready}, 5'b0);
    check("async_rst_rsp", rsp, 2'b00);
    check("async_rst_dla", dla_data, '0);
    step(2);
    ready_mode = 0;
    @(negedge clk); #1 rstn = 1;
    step(1);
    check("rst_no_pulse", 64'(wr_pulses - wb + rd_pulses - rb), 64'd0);
    for (int i = 0; i < 300 && (wr_pulses - wb < 2 || rd_pulses - rb < 2); i++) step(1);
    req = 2'b00;
    check("post_rst_wr", 64'(wr_pulses - wb >= 2), 64'd1);
    check("post_rst_rd", 64'(rd_pulses - rb >= 2), 64'd1);
    step(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
